instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Fetch stage of the 16-bit CPU. Holds the PC and issues requests to instruction memory.
- Drives the IF/ID register that feeds the control unit's 4-bit opcode input and the register file's index fields.
- Supports a hazard stall, a branch redirect/flush, and a one-entry skid buffer, so no fetched word is lost while decode is stalled.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- NOP_INSTR, 16'h0000, instruction word inserted on bubbles and flushes.
- PC_STEP, 2, PC increment per fetched instruction (byte addressing).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- IMemReq  out  1  instruction-memory request.
- IMemAddr  out  16  fetch address; always equals the PC.
- IMemReady  in  1  memory has IMemData valid this cycle; it may rise in the same cycle as IMemReq.
- IMemData  in  16  instruction word.
- Stall  in  1  decode cannot accept; IF/ID holds.
- BranchTaken  in  1  redirect request from the branch resolve logic.
- BranchTarget  in  16  redirect address; bit 0 is forced to 0.
- IR  out  16  IF/ID instruction register.
- OPCODE  out  4  IR[15:12]; drives the control unit.
- PcPlus2  out  16  address of the instruction in IR plus PC_STEP, registered together with IR.
- IfValid  out  1  IR holds a real instruction, not a bubble.

Behaviour:
- Reset (Reset_n low at a clock edge):
  - PC=RESET_PC, IR=NOP_INSTR, PcPlus2=0, IfValid=0, skid buffer cleared, state=S_FETCH.
  - IMemReq goes low during the reset cycle and high from the first cycle after release.
- Reset asserted mid-operation discards any buffered word and any in-flight request.
- State S_FETCH: IMemReq=1 and IMemAddr=PC. Cases are evaluated in priority order:
  1. BranchTaken: PC<=BranchTarget&~1, IR<=NOP_INSTR, IfValid<=0. Any IMemData this cycle is discarded. The memory tolerates the address change. Stay in S_FETCH.
  2. IMemReady && !Stall: IR<=IMemData, PcPlus2<=PC+PC_STEP, IfValid<=1, PC<=PC+PC_STEP.
  3. IMemReady && Stall: Buf<=IMemData, BufPc<=PC+PC_STEP, PC<=PC+PC_STEP. IR, PcPlus2 and IfValid hold. Go to S_HOLD.
  4. !IMemReady && !Stall: IR<=NOP_INSTR, IfValid<=0 (bubble). PC holds.
  5. !IMemReady && Stall: all state holds.
- State S_HOLD: IMemReq=0. Cases are evaluated in priority order:
  1. BranchTaken: drop Buf, PC<=target, IR<=NOP_INSTR, IfValid<=0. Go to S_FETCH.
  2. !Stall: IR<=Buf, PcPlus2<=BufPc, IfValid<=1. Go to S_FETCH; the next request goes out in that cycle.
  3. Stall: hold.
- Stall never blocks a redirect, and BranchTaken always wins over Stall.
- Latency: with zero-wait memory, address to IR is 1 cycle and the pipe sustains one instruction per cycle.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 wraps to 16'h0000, with no flag.
- OPCODE is purely combinational from IR, so after reset it is 4'b0000.

Optional Feature:
- Macro: IF_FETCH_COUNT_EN.
- When defined, the block adds the output FetchCount (out, 16). It is a counter that increments on each cycle where IR loads a real instruction (S_FETCH case 2 or S_HOLD case 2).
  - Reset value is 0.
  - It wraps at 16'hFFFF to 0.
  - Flushed and discarded words are not counted.
- When undefined, the port and its logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then zero-wait memory returning addr+16'h1000 -> IMemAddr 0000,0002,0004; IR 1000,1002,1004 one cycle later; IfValid=1 from the second cycle; PcPlus2 0002,0004,0006.
- Stall high for 3 cycles while IMemReady=1 at PC=0006 -> IR holds its prior word; Buf=1006; IMemReq=0 in S_HOLD; after Stall drops, IR=1006 and then the fetch of 0008 follows. No word is lost or duplicated.
- BranchTaken with BranchTarget=16'h0041 while in S_HOLD with Stall=1 -> next cycle PC=0040, IR=NOP_INSTR, IfValid=0, Buf dropped; next IR=1040.
- IMemReady low for 2 cycles at PC=0010, Stall=0 -> two bubbles (IfValid=0, IR=0000, OPCODE=0000) and IMemAddr stable at 0010.
- PC set to FFFE via branch -> fetches FFFE and then 0000; PcPlus2 for FFFE is 0000.
- With IF_FETCH_COUNT_EN: 5 real fetches, 1 flush, 2 bubbles -> FetchCount=5. Reset_n low mid-run -> FetchCount=0, IfValid=0, PC=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage of the 16-bit CPU: PC, instruction-memory request, IF/ID register and one-entry skid buffer.
// Optional macro IF_FETCH_COUNT_EN adds a FetchCount output counting real instructions loaded into IR.
module instr_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [15:0] IMemData,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic [15:0] IR,
    output logic [3:0]  OPCODE,
    output logic [15:0] PcPlus2,
    output logic        IfValid
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [15:0] FetchCount
`endif
);

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        if_valid_q, if_valid_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] buf_pc_q, buf_pc_d;
    logic        load_real;

    logic [15:0] pc_inc;
    logic [15:0] branch_pc;

    assign pc_inc    = pc_q + PC_STEP;
    assign branch_pc = BranchTarget & ~16'h0001;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        pc_plus2_d = pc_plus2_q;
        if_valid_d = if_valid_q;
        buf_d      = buf_q;
        buf_pc_d   = buf_pc_q;
        load_real  = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (BranchTaken) begin
                    pc_d       = branch_pc;
                    ir_d       = NOP_INSTR;
                    if_valid_d = 1'b0;
                end else if (IMemReady && !Stall) begin
                    ir_d       = IMemData;
                    pc_plus2_d = pc_inc;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc;
                    load_real  = 1'b1;
                end else if (IMemReady && Stall) begin
                    // Decode is full: park the returned word so it is not lost.
                    buf_d      = IMemData;
                    buf_pc_d   = pc_inc;
                    pc_d       = pc_inc;
                    state_d    = S_HOLD;
                end else if (!Stall) begin
                    ir_d       = NOP_INSTR;
                    if_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (BranchTaken) begin
                    pc_d       = branch_pc;
                    ir_d       = NOP_INSTR;
                    if_valid_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (!Stall) begin
                    ir_d       = buf_q;
                    pc_plus2_d = buf_pc_q;
                    if_valid_d = 1'b1;
                    load_real  = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
        if (!Reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            if_valid_q <= 1'b0;
            buf_q      <= 16'h0000;
            buf_pc_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pc_plus2_q <= pc_plus2_d;
            if_valid_q <= if_valid_d;
            buf_q      <= buf_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    assign fetch_count_d = fetch_count_q + {15'd0, load_real};

    always_ff @(posedge Clock) begin
        if (!Reset_n) fetch_count_q <= 16'h0000;
        else          fetch_count_q <= fetch_count_d;
    end

    assign FetchCount = fetch_count_q;
`endif

    // Request is gated by reset so it is low for every cycle Reset_n is held.
    assign IMemReq  = Reset_n && (state_q == S_FETCH);
    assign IMemAddr = pc_q;
    assign IR       = ir_q;
    assign OPCODE   = ir_q[15:12];
    assign PcPlus2  = pc_plus2_q;
    assign IfValid  = if_valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: vector table plus reset sequences.
// Memory model answers every address with addr + 16'h1000 whenever ready is driven high.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [15:0] pc_plus2;
    logic        if_valid;
`ifdef IF_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr + 16'h1000;

    instr_fetch_stage dut (
        .Clock       (clk),
        .Reset_n     (rst_n),
        .IMemReq     (imem_req),
        .IMemAddr    (imem_addr),
        .IMemReady   (imem_ready),
        .IMemData    (imem_data),
        .Stall       (stall),
        .BranchTaken (branch_taken),
        .BranchTarget(branch_target),
        .IR          (ir),
        .OPCODE      (opcode),
        .PcPlus2     (pc_plus2),
        .IfValid     (if_valid)
`ifdef IF_FETCH_COUNT_EN
        ,
        .FetchCount  (fetch_count)
`endif
    );

    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic [15:0] target;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic [15:0] exp_ir;
        logic        exp_valid;
        logic [15:0] exp_pc2;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [15:0] t,
                                input logic rq, input logic [15:0] a, input logic [15:0] i,
                                input logic v, input logic [15:0] p, input logic [15:0] c);
        vec_t x;
        x.stall = s; x.ready = r; x.br = b; x.target = t;
        x.exp_req = rq; x.exp_addr = a; x.exp_ir = i; x.exp_valid = v; x.exp_pc2 = p; x.exp_cnt = c;
        return x;
    endfunction

    initial begin
        //             stall rdy br  target    req addr      ir        vld pc2       cnt
        vecs[0]  = mk(0, 1, 0, 16'h0000, 1, 16'h0000, 16'h1000, 1, 16'h0002, 16'd1);
        vecs[1]  = mk(0, 1, 0, 16'h0000, 1, 16'h0002, 16'h1002, 1, 16'h0004, 16'd2);
        vecs[2]  = mk(0, 1, 0, 16'h0000, 1, 16'h0004, 16'h1004, 1, 16'h0006, 16'd3);
        vecs[3]  = mk(1, 1, 0, 16'h0000, 1, 16'h0006, 16'h1004, 1, 16'h0006, 16'd3);
        vecs[4]  = mk(1, 1, 0, 16'h0000, 0, 16'h0008, 16'h1004, 1, 16'h0006, 16'd3);
        vecs[5]  = mk(1, 1, 0, 16'h0000, 0, 16'h0008, 16'h1004, 1, 16'h0006, 16'd3);
        vecs[6]  = mk(0, 1, 0, 16'h0000, 0, 16'h0008, 16'h1006, 1, 16'h0008, 16'd4);
        vecs[7]  = mk(0, 1, 0, 16'h0000, 1, 16'h0008, 16'h1008, 1, 16'h000A, 16'd5);
        vecs[8]  = mk(1, 1, 0, 16'h0000, 1, 16'h000A, 16'h1008, 1, 16'h000A, 16'd5);
        vecs[9]  = mk(1, 1, 1, 16'h0041, 0, 16'h000C, 16'h0000, 0, 16'h000A, 16'd5);
        vecs[10] = mk(0, 1, 0, 16'h0000, 1, 16'h0040, 16'h1040, 1, 16'h0042, 16'd6);
        vecs[11] = mk(0, 1, 1, 16'h0010, 1, 16'h0042, 16'h0000, 0, 16'h0042, 16'd6);
        vecs[12] = mk(0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0000, 0, 16'h0042, 16'd6);
        vecs[13] = mk(0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0000, 0, 16'h0042, 16'd6);
        vecs[14] = mk(0, 1, 0, 16'h0000, 1, 16'h0010, 16'h1010, 1, 16'h0012, 16'd7);
        vecs[15] = mk(1, 0, 0, 16'h0000, 1, 16'h0012, 16'h1010, 1, 16'h0012, 16'd7);
        vecs[16] = mk(0, 0, 1, 16'hFFFF, 1, 16'h0012, 16'h0000, 0, 16'h0012, 16'd7);
        vecs[17] = mk(0, 1, 0, 16'h0000, 1, 16'hFFFE, 16'h0FFE, 1, 16'h0000, 16'd8);
        vecs[18] = mk(0, 1, 0, 16'h0000, 1, 16'h0000, 16'h1000, 1, 16'h0002, 16'd9);
        vecs[19] = mk(1, 1, 1, 16'h0100, 1, 16'h0002, 16'h0000, 0, 16'h0002, 16'd9);
        vecs[20] = mk(0, 1, 0, 16'h0000, 1, 16'h0100, 16'h1100, 1, 16'h0102, 16'd10);

        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        @(posedge clk); #1;
        check("rst_req", {15'd0, imem_req}, 16'd0);
        @(posedge clk); #1;
        check("rst_req2", {15'd0, imem_req}, 16'd0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_opcode", {12'd0, opcode}, 16'd0);
        check("rst_pc2", pc_plus2, 16'h0000);
        check("rst_valid", {15'd0, if_valid}, 16'd0);
`ifdef IF_FETCH_COUNT_EN
        check("rst_cnt", fetch_count, 16'd0);
`endif
        rst_n = 1'b1;

        for (int k = 0; k < 21; k++) begin
            stall = vecs[k].stall; imem_ready = vecs[k].ready;
            branch_taken = vecs[k].br; branch_target = vecs[k].target;
            #1;
            check($sformatf("v%0d_req", k), {15'd0, imem_req}, {15'd0, vecs[k].exp_req});
            check($sformatf("v%0d_addr", k), imem_addr, vecs[k].exp_addr);
            @(posedge clk); #1;
            check($sformatf("v%0d_ir", k), ir, vecs[k].exp_ir);
            check($sformatf("v%0d_opcode", k), {12'd0, opcode}, {12'd0, vecs[k].exp_ir[15:12]});
            check($sformatf("v%0d_valid", k), {15'd0, if_valid}, {15'd0, vecs[k].exp_valid});
            check($sformatf("v%0d_pc2", k), pc_plus2, vecs[k].exp_pc2);
`ifdef IF_FETCH_COUNT_EN
            check($sformatf("v%0d_cnt", k), fetch_count, vecs[k].exp_cnt);
`endif
        end

        // Park a word in the skid buffer, then reset: the buffered word must vanish.
        stall = 1'b1; imem_ready = 1'b1; branch_taken = 1'b0;
        @(posedge clk); #1;
        check("park_ir", ir, 16'h1100);
        stall = 1'b0; rst_n = 1'b0;
        #1;
        check("midrst_req", {15'd0, imem_req}, 16'd0);
        @(posedge clk); #1;
        check("midrst_addr", imem_addr, 16'h0000);
        check("midrst_ir", ir, 16'h0000);
        check("midrst_valid", {15'd0, if_valid}, 16'd0);
        check("midrst_pc2", pc_plus2, 16'h0000);
`ifdef IF_FETCH_COUNT_EN
        check("midrst_cnt", fetch_count, 16'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("post_req", {15'd0, imem_req}, 16'd1);
        check("post_addr", imem_addr, 16'h0000);
        @(posedge clk); #1;
        check("post_ir", ir, 16'h1000);
        check("post_valid", {15'd0, if_valid}, 16'd1);
        check("post_pc2", pc_plus2, 16'h0002);
`ifdef IF_FETCH_COUNT_EN
        check("post_cnt", fetch_count, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
